// File: rtl/time_ring_core.sv
// Real-time clock core with an HH:MM:SS BCD counter, an alarm register and a timed ring output.
// A prescaler divides clk into 1 s ticks; the ring lasts RING_SEC ticks or ends on ring_stop.
module time_ring_core #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int RING_SEC = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_clk,
  input  logic        clock_load,
  input  logic        ring_load,
  input  logic [15:0] data_in,
  input  logic        mode_ring,
  input  logic        mode_ring_ad,
  input  logic        ring_stop,
  output logic [15:0] data_out,
  output logic [7:0]  sec_out,
  output logic        ring
);

  localparam int             PW        = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(CLK_FREQ - 1);
  localparam logic [7:0]     RING_MAX  = 8'(RING_SEC);

  logic [PW-1:0] presc;
  logic [3:0]    ht, hu, mt, mu, st, su;
  logic [3:0]    ht_n, hu_n, mt_n, mu_n, st_n, su_n;
  logic [15:0]   alarm;
  logic [7:0]    ring_cnt;
  logic          data_ok, clk_ld, rng_ld, tick, adv, alarm_hit;

  function automatic logic bcd_hm_ok(input logic [15:0] d);
    return (d[15:12] <= 4'd2) && (d[11:8] <= 4'd9) && (d[7:4] <= 4'd5) &&
           (d[3:0] <= 4'd9) && !((d[15:12] == 4'd2) && (d[11:8] > 4'd3));
  endfunction

  assign data_ok = bcd_hm_ok(data_in);
  assign clk_ld  = clock_load & data_ok;
  assign rng_ld  = ring_load & data_ok;
  assign tick    = en_clk & (presc == PRESC_MAX);
  // A valid clock_load swallows a coincident tick, including its effect on the ring counter.
  assign adv     = tick & ~clk_ld;

  always_comb begin
    su_n = su; st_n = st; mu_n = mu; mt_n = mt; hu_n = hu; ht_n = ht;
    if (su != 4'd9) su_n = su + 4'd1;
    else begin
      su_n = 4'd0;
      if (st != 4'd5) st_n = st + 4'd1;
      else begin
        st_n = 4'd0;
        if (mu != 4'd9) mu_n = mu + 4'd1;
        else begin
          mu_n = 4'd0;
          if (mt != 4'd5) mt_n = mt + 4'd1;
          else begin
            mt_n = 4'd0;
            if ((ht == 4'd2) && (hu == 4'd3)) begin
              ht_n = 4'd0;
              hu_n = 4'd0;
            end else if (hu != 4'd9) hu_n = hu + 4'd1;
            else begin
              hu_n = 4'd0;
              ht_n = ht + 4'd1;
            end
          end
        end
      end
    end
  end

  assign alarm_hit = adv && ({st_n, su_n} == 8'h00) && ({ht_n, hu_n, mt_n, mu_n} == alarm);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc <= '0;
    else if (clk_ld) presc <= '0;
    else if (en_clk) presc <= tick ? '0 : presc + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {ht, hu, mt, mu, st, su} <= '0;
    end else if (clk_ld) begin
      {ht, hu, mt, mu} <= data_in;
      {st, su}         <= 8'h00;
    end else if (adv) begin
      {ht, hu, mt, mu, st, su} <= {ht_n, hu_n, mt_n, mu_n, st_n, su_n};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm    <= 16'h0700;
      ring     <= 1'b0;
      ring_cnt <= '0;
    end else begin
      if (rng_ld) alarm <= data_in;
      if (rng_ld || ring_stop) begin
        ring     <= 1'b0;
        ring_cnt <= '0;
      end else if (alarm_hit) begin
        ring     <= 1'b1;
        ring_cnt <= '0;
      end else if (adv && ring) begin
        if (ring_cnt + 8'd1 == RING_MAX) begin
          ring     <= 1'b0;
          ring_cnt <= '0;
        end else begin
          ring_cnt <= ring_cnt + 8'd1;
        end
      end
    end
  end

  assign data_out = (mode_ring | mode_ring_ad) ? alarm : {ht, hu, mt, mu};
  assign sec_out  = {st, su};

endmodule

// File: doc/time_ring_core.md
TIME_RING_CORE -- requirements
Module: time_ring_core

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000: clk cycles per 1 s tick.
REQ-002 SHALL have parameter RING_SEC, default 10: ring duration in seconds, range 1..255.
REQ-003 SHALL have port clk, input, 1: the single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port en_clk, input, 1: 1 = timekeeping runs; 0 = prescaler and time frozen.
REQ-006 SHALL have port clock_load, input, 1: one-cycle strobe; load time HH:MM from data_in.
REQ-007 SHALL have port ring_load, input, 1: one-cycle strobe; load alarm HH:MM from data_in.
REQ-008 SHALL have port data_in, input, 16: BCD {Ht[15:12], Hu[11:8], Mt[7:4], Mu[3:0]}.
REQ-009 SHALL have port mode_ring, input, 1: alarm-display mode select.
REQ-010 SHALL have port mode_ring_ad, input, 1: alarm-adjust mode select.
REQ-011 SHALL have port ring_stop, input, 1: one-cycle strobe; silence active ring.
REQ-012 SHALL have port data_out, output, 16: BCD HH:MM of time or alarm, same packing as data_in.
REQ-013 SHALL have port sec_out, output, 8: BCD seconds {St[7:4], Su[3:0]}.
REQ-014 SHALL have port ring, output, 1: alarm active.

Function
REQ-015 SHALL count prescaler 0..CLK_FREQ-1 while en_clk=1; tick = one-cycle pulse when count = CLK_FREQ-1, count then wraps to 0.
REQ-016 SHALL hold prescaler and suppress tick while en_clk=0; resume from held value.
REQ-017 SHALL on tick advance time in BCD: Su 9->0 carries to St; St:Su 59->00 carries to minutes; minutes 59->00 carries to hours; 23:59:59 -> 00:00:00.
REQ-018 SHALL on clock_load with valid data_in: load hours/minutes, clear seconds to 00 and prescaler to 0, same cycle; takes effect next edge.
REQ-019 SHALL treat data_in valid only if every nibble <= 9, Ht:Hu <= 23, Mt <= 5; invalid load strobes ignored (no state change).
REQ-020 SHALL give clock_load priority over tick in same cycle; the tick is discarded.
REQ-021 SHALL on ring_load with valid data_in load alarm register and clear ring and ring counter.
REQ-022 SHALL assert ring on the edge following a tick that produces time HH:MM:00 with HH:MM = alarm.
REQ-023 SHALL not start ring from clock_load even if loaded time equals alarm.
REQ-024 SHALL hold ring high for RING_SEC ticks, counted by 8-bit ring counter; drop ring on the edge after the RING_SEC-th tick.
REQ-025 SHALL freeze ring counter while en_clk=0 (ring stays high).
REQ-026 SHALL clear ring on ring_stop; ring_stop has priority over a same-cycle alarm match.
REQ-027 SHALL restart ring duration if match occurs while ring already high (unreachable at RING_SEC<60, defined for completeness).
REQ-028 SHALL drive data_out combinationally: alarm if (mode_ring | mode_ring_ad), else current HH:MM.
REQ-029 SHALL drive sec_out from seconds register regardless of mode.

Reset
REQ-030 SHALL on rst_n=0 asynchronously set time 00:00:00, alarm 07:00 (16'h0700), prescaler 0, ring counter 0, ring 0; data_out = 16'h0000 with modes 0.
REQ-031 SHALL resume counting on first edge after rst_n deasserts; reset mid-ring clears ring immediately.

Verification (CLK_FREQ=4, RING_SEC=3)
REQ-032 SHALL cover rollover: clock_load 16'h2359, run 60 ticks -> data_out 16'h0000, sec_out 8'h00.
REQ-033 SHALL cover invalid loads: clock_load 16'h2460, then 16'h1A00 -> time unchanged; ring_load 16'h0960 -> alarm unchanged (data_out 16'h0700 with mode_ring=1).
REQ-034 SHALL cover alarm: ring_load 16'h0801, clock_load 16'h0800, 60 ticks -> ring rises at 08:01:00, falls after 3 ticks at 08:01:03.
REQ-035 SHALL cover stop/priority: ring active, ring_stop -> ring 0 next edge; clock_load same cycle as tick -> seconds 00, prescaler 0.
REQ-036 SHALL cover en_clk=0 for 20 cycles -> time, prescaler, ring counter frozen; rst_n pulse mid-ring -> ring 0, time 00:00:00, alarm 07:00.
